seq_monitor: RTL and testbench

SEQ_MONITOR -- requirements
Module: seq_monitor

---
 rtl/seq_monitor_pkg.sv | 13 +
 rtl/sat_counter.sv | 43 ++++
 rtl/seq_monitor.sv | 115 +++++++++++
 tb/tb_seq_monitor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_monitor_pkg.sv
// Shared types and default sizing for the count-sequence monitor.
package seq_monitor_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        TRACK  = 1'b1
    } state_t;

    localparam int DEFAULT_MODULUS = 7;
    localparam int DEFAULT_WIDTH   = 3;
    localparam int DEFAULT_CW      = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; an increment in the same cycle as clr counts
// from a freshly cleared value, so the event is never lost.
module sat_counter
    import seq_monitor_pkg::*;
#(
    parameter int CW = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] q
);

    localparam logic [CW-1:0] MAX = '1;

    logic [CW-1:0] q_q;
    logic [CW-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (inc) begin
            if (clr) begin
                q_d = CW'(1);
            end else if (q_q != MAX) begin
                q_d = q_q + 1'b1;
            end
        end else if (clr) begin
            q_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/seq_monitor.sv
// Watches a mod-MODULUS count stream: locks on a 0, then flags every sample
// that does not follow the expected successor. All outputs are registered.
module seq_monitor
    import seq_monitor_pkg::*;
#(
    parameter int MODULUS = DEFAULT_MODULUS,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int CW      = DEFAULT_CW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt,
    input  logic             cnt_vld,
    input  logic             clr_err,
    output logic             locked,
    output logic             wrap,
    output logic [CW-1:0]    cyc_cnt,
    output logic             seq_err,
    output logic             err_sticky,
    output logic [CW-1:0]    err_cnt
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             wrap_q, wrap_d;
    logic             seq_err_q, viol_d;
    logic             err_sticky_q, err_sticky_d;
    logic             out_of_range;

    // The next expected value is always the successor of the accepted sample,
    // whether it matched or is a 0 that restarts tracking.
    function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] v);
        return (v == LAST) ? '0 : v + 1'b1;
    endfunction

    assign out_of_range = (int'(cnt) >= MODULUS);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        wrap_d  = 1'b0;
        viol_d  = 1'b0;
        if (cnt_vld) begin
            case (state_q)
                SEARCH: begin
                    if (cnt == '0) begin
                        state_d = TRACK;
                        exp_d   = succ(cnt);
                    end else if (out_of_range) begin
                        viol_d = 1'b1;
                    end
                end
                TRACK: begin
                    if (cnt == exp_q) begin
                        exp_d  = succ(cnt);
                        wrap_d = (cnt == LAST);
                    end else begin
                        viol_d = 1'b1;
                        if (cnt == '0) begin
                            exp_d = succ(cnt);
                        end else begin
                            state_d = SEARCH;
                            exp_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                    exp_d   = '0;
                end
            endcase
        end
        err_sticky_d = viol_d ? 1'b1 : (clr_err ? 1'b0 : err_sticky_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SEARCH;
            exp_q        <= '0;
            wrap_q       <= 1'b0;
            seq_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            wrap_q       <= wrap_d;
            seq_err_q    <= viol_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    sat_counter #(.CW(CW)) u_cyc_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (wrap_d),
        .q   (cyc_cnt)
    );

    sat_counter #(.CW(CW)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_err),
        .inc (viol_d),
        .q   (err_cnt)
    );

    assign locked     = (state_q == TRACK);
    assign wrap       = wrap_q;
    assign seq_err    = seq_err_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_seq_monitor.sv
// Directed bench for seq_monitor: a default instance plus a CW=2 instance
// sharing the same stimulus for the saturation check.
module tb_seq_monitor;

    logic       clk;
    logic       rst;
    logic [2:0] cnt;
    logic       cnt_vld;
    logic       clr_err;

    logic       locked, wrap, seq_err, err_sticky;
    logic [7:0] cyc_cnt, err_cnt;
    logic       locked_2, wrap_2, seq_err_2, err_sticky_2;
    logic [1:0] cyc_cnt_2, err_cnt_2;

    int total = 0;
    int bad   = 0;

    seq_monitor dut (
        .clk(clk), .rst(rst), .cnt(cnt), .cnt_vld(cnt_vld), .clr_err(clr_err),
        .locked(locked), .wrap(wrap), .cyc_cnt(cyc_cnt), .seq_err(seq_err),
        .err_sticky(err_sticky), .err_cnt(err_cnt)
    );

    seq_monitor #(.MODULUS(7), .WIDTH(3), .CW(2)) dut_cw2 (
        .clk(clk), .rst(rst), .cnt(cnt), .cnt_vld(cnt_vld), .clr_err(clr_err),
        .locked(locked_2), .wrap(wrap_2), .cyc_cnt(cyc_cnt_2), .seq_err(seq_err_2),
        .err_sticky(err_sticky_2), .err_cnt(err_cnt_2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: present one cycle of inputs, then sample 1 ns after the edge.
    task automatic drive(input logic vld, input logic [2:0] c, input logic clr);
        cnt_vld = vld;
        cnt     = c;
        clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cnt_vld = 1'b0;
        clr_err = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cnt_vld = 1'b0; cnt = 3'd0; clr_err = 1'b0;
        #20;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0b want=0", locked); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%0b want=0", wrap); end
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL reset_seq_err got=%0b want=0", seq_err); end
        total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%0b want=0", err_sticky); end
        total++; if (cyc_cnt !== 8'd0) begin bad++; $display("FAIL reset_cyc_cnt got=%0d want=0", cyc_cnt); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
        total++; if ({locked_2, wrap_2, seq_err_2, err_sticky_2, cyc_cnt_2, err_cnt_2} !== 8'd0) begin
            bad++; $display("FAIL reset_cw2 got=%0b want=0", {locked_2, wrap_2, seq_err_2, err_sticky_2, cyc_cnt_2, err_cnt_2});
        end
        rst = 1'b0;
    endtask

    // Free-running counter starting at 3: lock on the first 0, wrap after each 6.
    task automatic test_free_run();
        bit seen0 = 1'b0;
        bit locked_before;
        bit exp_wrap;
        int exp_cyc = 0;
        for (int i = 0; i < 25; i++) begin
            logic [2:0] c;
            c = 3'((3 + i) % 7);
            locked_before = seen0;
            if (c == 3'd0) seen0 = 1'b1;
            exp_wrap = locked_before && (c == 3'd6);
            if (exp_wrap) exp_cyc++;
            drive(1'b1, c, 1'b0);
            total++; if (locked !== seen0) begin bad++; $display("FAIL run_locked i=%0d got=%0b want=%0b", i, locked, seen0); end
            total++; if (wrap !== exp_wrap) begin bad++; $display("FAIL run_wrap i=%0d got=%0b want=%0b", i, wrap, exp_wrap); end
            total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL run_seq_err i=%0d got=%0b want=0", i, seq_err); end
            total++; if (cyc_cnt !== 8'(exp_cyc)) begin bad++; $display("FAIL run_cyc_cnt i=%0d got=%0d want=%0d", i, cyc_cnt, exp_cyc); end
        end
        total++; if (cyc_cnt !== 8'd3) begin bad++; $display("FAIL run_cyc_final got=%0d want=3", cyc_cnt); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL run_err_cnt got=%0d want=0", err_cnt); end
    endtask

    // 0,1,2,4: error after the 4, drop lock, relock on the next 0.
    task automatic test_skip();
        do_reset();
        drive(1'b1, 3'd0, 1'b0);
        drive(1'b1, 3'd1, 1'b0);
        drive(1'b1, 3'd2, 1'b0);
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL skip_pre_err got=%0b want=0", seq_err); end
        drive(1'b1, 3'd4, 1'b0);
        total++; if (seq_err !== 1'b1) begin bad++; $display("FAIL skip_seq_err got=%0b want=1", seq_err); end
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL skip_err_cnt got=%0d want=1", err_cnt); end
        total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL skip_sticky got=%0b want=1", err_sticky); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL skip_locked got=%0b want=0", locked); end
        drive(1'b0, 3'd5, 1'b0);
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL skip_pulse_len got=%0b want=0", seq_err); end
        total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL skip_sticky_hold got=%0b want=1", err_sticky); end
        drive(1'b1, 3'd0, 1'b0);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL skip_relock got=%0b want=1", locked); end
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL skip_err_cnt_hold got=%0d want=1", err_cnt); end
    endtask

    // 0,1,2,0,1,2: single error at the early 0, lock kept, tracking resumes.
    task automatic test_early_zero();
        do_reset();
        drive(1'b1, 3'd0, 1'b0);
        drive(1'b1, 3'd1, 1'b0);
        drive(1'b1, 3'd2, 1'b0);
        drive(1'b1, 3'd0, 1'b0);
        total++; if (seq_err !== 1'b1) begin bad++; $display("FAIL ez_seq_err got=%0b want=1", seq_err); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL ez_locked got=%0b want=1", locked); end
        drive(1'b1, 3'd1, 1'b0);
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL ez_after1 got=%0b want=0", seq_err); end
        drive(1'b1, 3'd2, 1'b0);
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL ez_after2 got=%0b want=0", seq_err); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL ez_locked_end got=%0b want=1", locked); end
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL ez_err_cnt got=%0d want=1", err_cnt); end
    endtask

    // Repeated value and idle cycles in TRACK.
    task automatic test_repeat_idle();
        do_reset();
        drive(1'b1, 3'd0, 1'b0);
        drive(1'b0, 3'd5, 1'b0);
        drive(1'b0, 3'd6, 1'b0);
        total++; if ({locked, wrap, seq_err} !== 3'b100) begin bad++; $display("FAIL idle_hold got=%0b want=100", {locked, wrap, seq_err}); end
        drive(1'b1, 3'd1, 1'b0);
        drive(1'b1, 3'd2, 1'b0);
        drive(1'b1, 3'd3, 1'b0);
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL idle_resume got=%0b want=0", seq_err); end
        drive(1'b1, 3'd3, 1'b0);
        total++; if (seq_err !== 1'b1) begin bad++; $display("FAIL repeat_err got=%0b want=1", seq_err); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL repeat_locked got=%0b want=0", locked); end
        drive(1'b1, 3'd4, 1'b0);
        total++; if ({locked, seq_err} !== 2'b00) begin bad++; $display("FAIL search_ignore got=%0b want=00", {locked, seq_err}); end
    endtask

    // Out-of-range sample in SEARCH, clr_err, and clr_err colliding with a violation.
    task automatic test_range_clear();
        do_reset();
        drive(1'b1, 3'd7, 1'b0);
        total++; if (seq_err !== 1'b1) begin bad++; $display("FAIL oor_seq_err got=%0b want=1", seq_err); end
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL oor_err_cnt got=%0d want=1", err_cnt); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL oor_locked got=%0b want=0", locked); end
        drive(1'b1, 3'd7, 1'b0);
        total++; if (err_cnt !== 8'd2) begin bad++; $display("FAIL oor_err_cnt2 got=%0d want=2", err_cnt); end
        drive(1'b0, 3'd0, 1'b1);
        total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL clr_sticky got=%0b want=0", err_sticky); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL clr_err_cnt got=%0d want=0", err_cnt); end
        drive(1'b1, 3'd7, 1'b0);
        drive(1'b1, 3'd7, 1'b1);
        total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL coll_sticky got=%0b want=1", err_sticky); end
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL coll_err_cnt got=%0d want=1", err_cnt); end
        drive(1'b1, 3'd0, 1'b1);
        total++; if ({locked, err_sticky} !== 2'b10) begin bad++; $display("FAIL clr_no_fsm got=%0b want=10", {locked, err_sticky}); end
    endtask

    // Five sequences saturate the CW=2 counter; async reset mid-sequence.
    task automatic test_sat_reset();
        do_reset();
        for (int s = 0; s < 5; s++) begin
            for (int v = 0; v < 7; v++) drive(1'b1, 3'(v), 1'b0);
            if (s == 2) begin
                total++; if (cyc_cnt_2 !== 2'd3) begin bad++; $display("FAIL sat_at3 got=%0d want=3", cyc_cnt_2); end
            end
        end
        total++; if (cyc_cnt_2 !== 2'd3) begin bad++; $display("FAIL sat_hold got=%0d want=3", cyc_cnt_2); end
        total++; if (cyc_cnt !== 8'd5) begin bad++; $display("FAIL sat_wide got=%0d want=5", cyc_cnt); end
        drive(1'b1, 3'd0, 1'b0);
        drive(1'b1, 3'd1, 1'b0);
        drive(1'b1, 3'd5, 1'b0);
        drive(1'b1, 3'd0, 1'b0);
        drive(1'b1, 3'd1, 1'b0);
        drive(1'b1, 3'd2, 1'b0);
        total++; if ({locked, err_sticky, err_cnt} !== 10'b11_0000_0001) begin
            bad++; $display("FAIL pre_rst got=%0b want=1100000001", {locked, err_sticky, err_cnt});
        end
        rst = 1'b1;
        #2;
        total++; if ({locked, wrap, seq_err, err_sticky} !== 4'b0000) begin
            bad++; $display("FAIL async_flags got=%0b want=0000", {locked, wrap, seq_err, err_sticky});
        end
        total++; if ({cyc_cnt, err_cnt} !== 16'd0) begin bad++; $display("FAIL async_cnts got=%0d/%0d want=0/0", cyc_cnt, err_cnt); end
        total++; if (cyc_cnt_2 !== 2'd0) begin bad++; $display("FAIL async_cw2 got=%0d want=0", cyc_cnt_2); end
        rst = 1'b0;
        drive(1'b1, 3'd3, 1'b0);
        total++; if ({locked, seq_err} !== 2'b00) begin bad++; $display("FAIL relock_needs0 got=%0b want=00", {locked, seq_err}); end
        drive(1'b1, 3'd0, 1'b0);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock got=%0b want=1", locked); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_skip();
        test_early_zero();
        test_repeat_idle();
        test_range_clear();
        test_sat_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
